ah_div_pipe_param: RTL and testbench

- Parametrised, fully pipelined restoring integer divider; successor to the fixed-width 256-bit/4-stage divider.
- Generalised in operand width and bits-per-stage.
- Adds per-operation signed/unsigned mode, remainder output, a transaction tag, valid/ready backpressure and signed-overflow detection.
- Sits in the arithmetic datapath; accepts one division per cycle and returns results in issue order.

---
 rtl/ah_div_pkg.sv | 21 ++
 rtl/ah_div_stage.sv | 62 ++++++
 rtl/ah_div_pipe_param.sv | 152 +++++++++++++++
 tb/tb_ah_div_pipe_param.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ah_div_pkg.sv
// Shared definitions for the pipelined restoring divider: stage count, config check, per-stage flag record.
package ah_div_pkg;

    function automatic int calc_nstage(input int width, input int bits_per_stage);
        return width / bits_per_stage;
    endfunction

    function automatic bit cfg_ok(input int width, input int bits_per_stage);
        return (bits_per_stage > 0) && (width >= bits_per_stage) && ((width % bits_per_stage) == 0);
    endfunction

    // Control bits that travel with each operation alongside its datapath fields.
    typedef struct packed {
        logic valid;
        logic qneg;
        logic rneg;
        logic dbz;
        logic ovf;
    } div_flags_t;

endpackage

// File: rtl/ah_div_stage.sv
// One registered restoring-division iteration: resolves BITS_PER_STAGE quotient bits MSB-first.
module ah_div_stage
    import ah_div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 4,
    parameter int TAG_W          = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               clr,
    input  logic [2*WIDTH-1:0] prev_pr,
    input  logic [WIDTH-1:0]   prev_dvs,
    input  div_flags_t         prev_flags,
    input  logic [TAG_W-1:0]   prev_tag,
    output logic [2*WIDTH-1:0] pr,
    output logic [WIDTH-1:0]   dvs,
    output div_flags_t         flags,
    output logic [TAG_W-1:0]   tag
);

    // Partial remainder layout: upper half is the running remainder, lower half holds the
    // dividend bits still to be consumed; quotient bits fill the vacated low end.
    logic [2*WIDTH-1:0] pr_next;
    logic [WIDTH:0]     trial;

    // NOTE: blocking assignments inside always_comb chain the per-bit iterations within one cycle.
    always_comb begin
        pr_next = prev_pr;
        trial   = '0;
        for (int i = 0; i < BITS_PER_STAGE; i++) begin
            trial   = {pr_next[2*WIDTH-1:WIDTH], pr_next[WIDTH-1]};
            pr_next = {pr_next[2*WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, prev_dvs}) begin
                trial      = trial - {1'b0, prev_dvs};
                pr_next[0] = 1'b1;
            end
            pr_next[2*WIDTH-1:WIDTH] = trial[WIDTH-1:0];
        end
    end

    // NOTE: last non-blocking write wins, so clr overrides the enabled load of the valid bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flags <= '0;
        end else begin
            if (en)  flags       <= prev_flags;
            if (clr) flags.valid <= 1'b0;
        end
    end

    // NOTE: datapath registers carry no reset; only the valid bit decides whether they matter.
    always_ff @(posedge clk) begin
        if (en) begin
            pr  <= pr_next;
            dvs <= prev_dvs;
            tag <= prev_tag;
        end
    end

endmodule

// File: rtl/ah_div_pipe_param.sv
// Parametrised pipelined signed/unsigned divider with tag, backpressure and dbz/overflow flags.
// Optional synchronous pipeline flush port enabled by defining AH_DIV_PIPE_FLUSH_EN.
module ah_div_pipe_param
    import ah_div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 4,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             rstn,
`ifdef AH_DIV_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               NSTAGE  = calc_nstage(WIDTH, BITS_PER_STAGE);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (!cfg_ok(WIDTH, BITS_PER_STAGE)) begin : g_cfg_err
            $error("ah_div_pipe_param: WIDTH must be a non-zero multiple of BITS_PER_STAGE");
        end
    endgenerate

    logic stall, en, clr;

    assign stall = out_valid && !out_ready;
    assign en    = !stall;
`ifdef AH_DIV_PIPE_FLUSH_EN
    assign clr   = flush;
`else
    assign clr   = 1'b0;
`endif
    assign in_ready = !stall && !clr;

    // Input stage: fold signs away so the iteration stages only see magnitudes.
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    div_flags_t       in_flags;

    always_comb begin
        neg_a          = in_signed && dividend[WIDTH-1];
        neg_b          = in_signed && divisor[WIDTH-1];
        abs_a          = neg_a ? -dividend : dividend;
        abs_b          = neg_b ? -divisor : divisor;
        in_flags.valid = in_valid && in_ready;
        in_flags.qneg  = neg_a ^ neg_b;
        in_flags.rneg  = neg_a;
        in_flags.dbz   = (divisor == '0);
        in_flags.ovf   = in_signed && (dividend == MIN_VAL) && (divisor == '1);
    end

    logic [2*WIDTH-1:0] s0_pr;
    logic [WIDTH-1:0]   s0_dvs;
    div_flags_t         s0_flags;
    logic [TAG_W-1:0]   s0_tag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_flags <= '0;
        end else begin
            if (en)  s0_flags       <= in_flags;
            if (clr) s0_flags.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s0_pr  <= {{WIDTH{1'b0}}, abs_a};
            s0_dvs <= abs_b;
            s0_tag <= in_tag;
        end
    end

    // Index 0 is the input stage; index k is the output of iteration stage k.
    logic [2*WIDTH-1:0] pr    [NSTAGE+1];
    logic [WIDTH-1:0]   dvs   [NSTAGE+1];
    div_flags_t         flags [NSTAGE+1];
    logic [TAG_W-1:0]   tag   [NSTAGE+1];

    assign pr[0]    = s0_pr;
    assign dvs[0]   = s0_dvs;
    assign flags[0] = s0_flags;
    assign tag[0]   = s0_tag;

    generate
        for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
            ah_div_stage #(
                .WIDTH          (WIDTH),
                .BITS_PER_STAGE (BITS_PER_STAGE),
                .TAG_W          (TAG_W)
            ) u_stage (
                .clk        (clk),
                .rstn       (rstn),
                .en         (en),
                .clr        (clr),
                .prev_pr    (pr[k]),
                .prev_dvs   (dvs[k]),
                .prev_flags (flags[k]),
                .prev_tag   (tag[k]),
                .pr         (pr[k+1]),
                .dvs        (dvs[k+1]),
                .flags      (flags[k+1]),
                .tag        (tag[k+1])
            );
        end
    endgenerate

    // Output stage: restore signs; divide-by-zero forces an all-ones quotient regardless of sign.
    div_flags_t       fin;
    logic [WIDTH-1:0] quo_raw, rem_raw;

    assign fin     = flags[NSTAGE];
    assign quo_raw = pr[NSTAGE][WIDTH-1:0];
    assign rem_raw = pr[NSTAGE][2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            out_tag     <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (en) begin
                out_valid   <= fin.valid;
                quotient    <= fin.dbz ? '1 : (fin.qneg ? -quo_raw : quo_raw);
                remainder   <= fin.rneg ? -rem_raw : rem_raw;
                out_tag     <= tag[NSTAGE];
                div_by_zero <= fin.valid && fin.dbz;
                overflow    <= fin.valid && fin.ovf;
            end
            if (clr) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ah_div_pipe_param.sv
// Self-checking bench for ah_div_pipe_param (WIDTH=32, BITS_PER_STAGE=4): arithmetic model plus directed vectors.
// Exercises the flush port as well when AH_DIV_PIPE_FLUSH_EN is defined.
module tb_ah_div_pipe_param;

    localparam int WIDTH = 32;
    localparam int BPS   = 4;
    localparam int TAG_W = 4;
    localparam int LAT   = 10;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_signed = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [TAG_W-1:0] out_tag;
    logic             div_by_zero;
    logic             overflow;
    logic             flushing;

`ifdef AH_DIV_PIPE_FLUSH_EN
    logic flush = 1'b0;
    assign flushing = flush;
`else
    assign flushing = 1'b0;
`endif

    ah_div_pipe_param #(.WIDTH(WIDTH), .BITS_PER_STAGE(BPS), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
`ifdef AH_DIV_PIPE_FLUSH_EN
        .flush       (flush),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .out_tag     (out_tag),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] tag;
        logic             dbz;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Division semantics straight from the arithmetic rules, using 64-bit host arithmetic.
    function automatic exp_t model(input logic sgn, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        exp_t   e;
        longint na, db;
        e.tag = tag;
        e.dbz = (b == 0);
        e.ovf = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (e.dbz) begin
            e.q = '1;
            e.r = a;
        end else if (sgn) begin
            na  = longint'($signed(a));
            db  = longint'($signed(b));
            e.q = 32'(na / db);
            e.r = 32'(na % db);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Scoreboard: outputs and handshakes are stable at the falling edge.
    always @(negedge clk) begin
        if (!rstn || flushing) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_expected_result", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("sb_quotient",  quotient,    mon_e.q);
                    check("sb_remainder", remainder,   mon_e.r);
                    check("sb_tag",       out_tag,     mon_e.tag);
                    check("sb_dbz",       div_by_zero, mon_e.dbz);
                    check("sb_ovf",       overflow,    mon_e.ovf);
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_signed, dividend, divisor, in_tag));
        end
    end

    task automatic set_in(input logic sgn, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
        in_signed = sgn;
        dividend  = a;
        divisor   = b;
        in_tag    = tag;
    endtask

    // One isolated operation with literal expectations and a latency measurement.
    task automatic single_op(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] eq,
                             input logic [WIDTH-1:0] er, input logic ed, input logic eo);
        int lat;
        @(posedge clk); #1;
        set_in(sgn, a, b, tag);
        in_valid = 1'b1;
        check("op_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("op_latency",   lat,         LAT);
        check("op_quotient",  quotient,    eq);
        check("op_remainder", remainder,   er);
        check("op_tag",       out_tag,     tag);
        check("op_dbz",       div_by_zero, ed);
        check("op_ovf",       overflow,    eo);
    endtask

    task automatic stream_ops();
        fork
            begin : producer
                int i = 0;
                int guard = 0;
                logic [WIDTH-1:0] a, b;
                while (i < 20 && guard < 200) begin
                    @(posedge clk); #1;
                    guard++;
                    a = 32'(i * 977) - 32'd5000;
                    if (i == 7)          b = '0;
                    else if (i % 4 == 0) b = 32'(-(i + 1));
                    else                 b = 32'(i + 3);
                    set_in(i[0], a, b, i[TAG_W-1:0]);
                    in_valid = 1'b1;
                    @(negedge clk);
                    if (in_ready) i++;
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
                check("stream_issued", i, 20);
            end
            begin : consumer
                int got = 0;
                int hold = 0;
                int low = 0;
                int guard = 0;
                while (got < 20 && guard < 300) begin
                    @(posedge clk); #1;
                    guard++;
                    out_ready = (hold == 0);
                    if (hold > 0) hold--;
                    @(negedge clk);
                    check("in_ready_rule", in_ready, 64'(!(out_valid && !out_ready)));
                    if (!in_ready) low++;
                    if (out_valid && out_ready) begin
                        // tags wrap at 4 bits
                        check("stream_order", out_tag, got[TAG_W-1:0]);
                        got++;
                        if (got == 4) hold = 3;
                    end
                end
                out_ready = 1'b1;
                check("stream_count", got, 20);
                check("stall_cycles", low, 3);
            end
        join
    endtask

    // Fill the pipe behind a stalled result so an abort has in-flight work to drop.
    task automatic load_stalled_pipe();
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_in(1'b0, 32'(1000 + k), 32'd3, k[TAG_W-1:0]);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_abort_valid", out_valid, 1);
        check("pre_abort_ready", in_ready, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid,   0);
        check("rst_quotient",  quotient,    0);
        check("rst_remainder", remainder,   0);
        check("rst_out_tag",   out_tag,     0);
        check("rst_dbz",       div_by_zero, 0);
        check("rst_ovf",       overflow,    0);
        check("rst_in_ready",  in_ready,    1);
        rstn = 1'b1;

        single_op(1'b0, 32'd100,        32'd7,          4'd3, 32'd14,         32'd2,          1'b0, 1'b0);
        single_op(1'b1, 32'hFFFF_FF9C,  32'd7,          4'd1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 1'b0);
        single_op(1'b1, 32'd100,        32'hFFFF_FFF9,  4'd2, 32'hFFFF_FFF2,  32'd2,          1'b0, 1'b0);
        single_op(1'b0, 32'd5,          32'd0,          4'd4, 32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0);
        single_op(1'b1, 32'd5,          32'd0,          4'd5, 32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0);
        single_op(1'b0, 32'd9,          32'd3,          4'd6, 32'd3,          32'd0,          1'b0, 1'b0);
        single_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  4'd7, 32'h8000_0000,  32'd0,          1'b0, 1'b1);
        single_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  4'd8, 32'd0,          32'h8000_0000,  1'b0, 1'b0);
        single_op(1'b0, 32'hFFFF_FFFE,  32'h8000_0001,  4'd9, 32'd1,          32'h7FFF_FFFD,  1'b0, 1'b0);
        single_op(1'b1, 32'hFFFF_FFF9,  32'd2,          4'hA, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0);
        single_op(1'b1, 32'hFFFF_FFF9,  32'd0,          4'hB, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1'b0);

        stream_ops();

        load_stalled_pipe();
        rstn = 1'b0;
        #1;
        check("abort_rst_valid", out_valid, 0);
        check("abort_rst_ready", in_ready,  1);
        @(posedge clk); #1;
        rstn      = 1'b1;
        out_ready = 1'b1;
        single_op(1'b0, 32'd1000, 32'd10, 4'hC, 32'd100, 32'd0, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        check("no_stale_valid", out_valid, 0);

`ifdef AH_DIV_PIPE_FLUSH_EN
        load_stalled_pipe();
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        single_op(1'b0, 32'd1000, 32'd10, 4'hD, 32'd100, 32'd0, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        check("no_stale_after_flush", out_valid, 0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
